// File: rtl/maze_cell_to_pixel_if.sv
// ============================================================================
//  Module   : maze_cell_to_pixel_if
//  Brief    : Cell-request handshake between game control and the cell mapper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface maze_cell_to_pixel_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_row;
  logic [7:0] req_col;

  modport master (
    output req_valid,
    output req_row,
    output req_col,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_row,
    input  req_col,
    output req_ready
  );
endinterface

`default_nettype wire

// File: rtl/maze_cell_to_pixel.sv
// ============================================================================
//  Module   : maze_cell_to_pixel
//  Brief    : Converts a requested maze cell into a target pixel by repeated
//             addition, then walks the sprite there one pixel per move_tick.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module maze_cell_to_pixel #(
  parameter int SF       = 60,
  parameter int S_X      = 150,
  parameter int S_Y      = 34,
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  maze_cell_to_pixel_if.slave    req,
  input  wire logic              move_tick,
  output logic [9:0]             xpos,
  output logic [9:0]             ypos,
  output logic [3:0]             direction,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_CALC  = 2'd1;
  localparam logic [1:0] C_ST_MOVE  = 2'd2;

  localparam logic [9:0] C_SF       = 10'(SF);
  localparam logic [9:0] C_S_X      = 10'(S_X);
  localparam logic [9:0] C_S_Y      = 10'(S_Y);
  localparam logic [7:0] C_NUM_ROWS = 8'(NUM_ROWS);
  localparam logic [7:0] C_NUM_COLS = 8'(NUM_COLS);

  localparam logic [3:0] C_DIR_LEFT  = 4'b0001;
  localparam logic [3:0] C_DIR_RIGHT = 4'b0010;
  localparam logic [3:0] C_DIR_UP    = 4'b0100;
  localparam logic [3:0] C_DIR_DOWN  = 4'b1000;

  logic [1:0] state_q, state_d;
  logic [7:0] row_q, row_d, col_q, col_d;
  logic [7:0] cnt_r_q, cnt_r_d, cnt_c_q, cnt_c_d;
  logic [9:0] tx_q, tx_d, ty_q, ty_d;
  logic [9:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [3:0] dir_q, dir_d;
  logic       done_q, done_d, err_q, err_d;

  logic w_accept;
  logic w_in_range;

  assign w_accept   = req.req_valid && (state_q == C_ST_IDLE);
  assign w_in_range = (req.req_row < C_NUM_ROWS) && (req.req_col < C_NUM_COLS);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_r_d = cnt_r_q;
    cnt_c_d = cnt_c_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      C_ST_IDLE: begin
        if (w_accept) begin
          if (w_in_range) begin
            row_d   = req.req_row;
            col_d   = req.req_col;
            tx_d    = C_S_X;
            ty_d    = C_S_Y;
            cnt_r_d = 8'd0;
            cnt_c_d = 8'd0;
            state_d = C_ST_CALC;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // Both axes accumulate in parallel, so latency follows the larger index.
      C_ST_CALC: begin
        if (cnt_c_q < col_q) begin
          tx_d    = tx_q + C_SF;
          cnt_c_d = cnt_c_q + 8'd1;
        end
        if (cnt_r_q < row_q) begin
          ty_d    = ty_q + C_SF;
          cnt_r_d = cnt_r_q + 8'd1;
        end
        if ((cnt_c_q == col_q) && (cnt_r_q == row_q)) begin
          state_d = C_ST_MOVE;
        end
      end

      C_ST_MOVE: begin
        if ((xpos_q == tx_q) && (ypos_q == ty_q)) begin
          done_d  = 1'b1;
          dir_d   = 4'b0000;
          state_d = C_ST_IDLE;
        end else if (move_tick) begin
          if (xpos_q != tx_q) begin
            if (xpos_q < tx_q) begin
              xpos_d = xpos_q + 10'd1;
              dir_d  = C_DIR_RIGHT;
            end else begin
              xpos_d = xpos_q - 10'd1;
              dir_d  = C_DIR_LEFT;
            end
          end else begin
            if (ypos_q < ty_q) begin
              ypos_d = ypos_q + 10'd1;
              dir_d  = C_DIR_DOWN;
            end else begin
              ypos_d = ypos_q - 10'd1;
              dir_d  = C_DIR_UP;
            end
          end
        end
      end

      default: begin
        state_d = C_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_ST_IDLE;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      cnt_r_q <= 8'd0;
      cnt_c_q <= 8'd0;
      tx_q    <= C_S_X;
      ty_q    <= C_S_Y;
      xpos_q  <= C_S_X;
      ypos_q  <= C_S_Y;
      dir_q   <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_r_q <= cnt_r_d;
      cnt_c_q <= cnt_c_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req.req_ready = (state_q == C_ST_IDLE);
  assign busy          = (state_q == C_ST_CALC) || (state_q == C_ST_MOVE);
  assign xpos          = xpos_q;
  assign ypos          = ypos_q;
  assign direction     = dir_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

`default_nettype wire
